// File: rtl/serial_bus_slave_port_if.sv
// Serial bus signal bundle between the interconnect (master side) and one
// slave port. The master drives the header/write lines, the slave returns
// read data, its ready flag and the error pulse.
interface serial_bus_slave_port_if;
  logic control;
  logic wD;
  logic valid;
  logic last;
  logic rD;
  logic rD_valid;
  logic ready;
  logic err;

  modport master (
    output control, wD, valid, last,
    input  rD, rD_valid, ready, err
  );

  modport slave (
    input  control, wD, valid, last,
    output rD, rD_valid, ready, err
  );
endinterface

// File: rtl/serial_bus_slave_port.sv
// Serial bus slave endpoint with an internal word memory.
// Header on control: 1,1,1 then ID | R/W (1=write) | burst | start address,
// all MSB first. Writes shift words in on wD (qualified by valid), reads
// shift words out on rD. Burst transfers auto-increment the address with
// wrap-around at MEM_DEPTH-1.
// Optional build macro SERIAL_SLAVE_TIMEOUT_EN: write idle timeout and
// read burst length limit, both reported by a one-cycle err pulse.
module serial_bus_slave_port #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_DEPTH      = 4096,
  parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
  parameter int SLAVES         = 3,
  parameter int SLAVE_ID_WIDTH = $clog2(SLAVES + 1),
  parameter int SLAVEID        = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rstN,
  serial_bus_slave_port_if.slave  bus
);

  localparam int HDR_LEN = SLAVE_ID_WIDTH + 2 + ADDR_WIDTH;
  localparam int HCW     = $clog2(HDR_LEN);
  localparam int BCW     = $clog2(DATA_WIDTH + 1);

  localparam logic [HCW-1:0]            ID_LAST   = HCW'(SLAVE_ID_WIDTH - 1);
  localparam logic [HCW-1:0]            HDR_LAST  = HCW'(HDR_LEN - 1);
  localparam logic [BCW-1:0]            BIT_LAST  = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]            BITS      = BCW'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]       DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [SLAVE_ID_WIDTH-1:0] MY_ID     = SLAVE_ID_WIDTH'(SLAVEID);

  typedef enum logic [2:0] {
    IDLE, HEADER, SKIP, WRITE, RD_LOAD, READ, FINISH
  } state_t;

  state_t                    state;
  logic [1:0]                ones_cnt;
  logic [HCW-1:0]            hdr_cnt;
  logic [HDR_LEN-2:0]        hdr_shift;
  logic                      is_burst;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-2:0]     wr_shift;
  logic [DATA_WIDTH-1:0]     out_shift;
  logic [DATA_WIDTH-1:0]     mem_q;
  logic                      rd_started;
  logic                      stop_req;

  logic [HDR_LEN-1:0]        hdr_next;
  logic [SLAVE_ID_WIDTH-1:0] id_early;
  logic [SLAVE_ID_WIDTH-1:0] hdr_id;
  logic                      hdr_rw;
  logic                      hdr_burst;
  logic [ADDR_WIDTH-1:0]     hdr_addr;
  logic                      id_ok_early;
  logic                      hdr_ok;
  logic [ADDR_WIDTH-1:0]     addr_inc;
  logic [DATA_WIDTH-1:0]     wr_word;
  logic                      mem_we;
  logic                      word_done;
  logic                      rd_stop;
  logic                      rd_over;
  logic                      rd_start;

  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];

`ifdef SERIAL_SLAVE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0]        idle_cnt;
  logic [ADDR_WIDTH:0]   word_cnt;
`endif

  // Header field extraction, address wrap, write word assembly and read sequencing decisions
  always_comb begin
    hdr_next    = {hdr_shift, bus.control};
    id_early    = hdr_next[SLAVE_ID_WIDTH-1:0];
    hdr_id      = hdr_next[HDR_LEN-1 -: SLAVE_ID_WIDTH];
    hdr_rw      = hdr_next[ADDR_WIDTH+1];
    hdr_burst   = hdr_next[ADDR_WIDTH];
    hdr_addr    = hdr_next[ADDR_WIDTH-1:0];
    // ID 0 is reserved and never addresses a slave
    id_ok_early = (id_early == MY_ID) && (id_early != '0);
    hdr_ok      = (hdr_id == MY_ID) && (hdr_id != '0) && ({1'b0, hdr_addr} < DEPTH_L);
    addr_inc    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    wr_word     = {wr_shift, bus.wD};
    mem_we      = (state == WRITE) && bus.valid && (bit_cnt == BIT_LAST);
    word_done   = rd_started && (bit_cnt == BITS);
    // last may arrive on any bit of a word, including its final bit
    rd_stop     = word_done && (!is_burst || stop_req || bus.last);
`ifdef SERIAL_SLAVE_TIMEOUT_EN
    rd_over     = word_done && !rd_stop && (word_cnt == DEPTH_L);
`else
    rd_over     = 1'b0;
`endif
    rd_start    = !rd_started || (word_done && !rd_stop && !rd_over);
  end

  // Word memory: write on the final bit of a word, registered read of the current address
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wr_word;
    end
    mem_q <= mem[addr];
  end

  // Control FSM with registered bus outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      ones_cnt      <= '0;
      hdr_cnt       <= '0;
      hdr_shift     <= '0;
      is_burst      <= 1'b0;
      addr          <= '0;
      bit_cnt       <= '0;
      wr_shift      <= '0;
      out_shift     <= '0;
      rd_started    <= 1'b0;
      stop_req      <= 1'b0;
      bus.ready     <= 1'b1;
      bus.rD        <= 1'b0;
      bus.rD_valid  <= 1'b0;
      bus.err       <= 1'b0;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
      idle_cnt      <= '0;
      word_cnt      <= '0;
`endif
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.control) begin
            if (ones_cnt == 2'd2) begin
              ones_cnt <= '0;
              hdr_cnt  <= '0;
              state    <= HEADER;
            end else begin
              ones_cnt <= ones_cnt + 2'd1;
            end
          end else begin
            ones_cnt <= '0;
          end
        end

        HEADER: begin
          hdr_shift <= hdr_next[HDR_LEN-2:0];
          hdr_cnt   <= hdr_cnt + 1'b1;
          if (hdr_cnt == ID_LAST && !id_ok_early) begin
            // Not ours: swallow the rest of the header silently
            state <= SKIP;
          end else if (hdr_cnt == HDR_LAST) begin
            if (!hdr_ok) begin
              state <= IDLE;
            end else begin
              is_burst   <= hdr_burst;
              addr       <= hdr_addr;
              bit_cnt    <= '0;
              rd_started <= 1'b0;
              stop_req   <= 1'b0;
              bus.ready  <= 1'b0;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
              idle_cnt   <= '0;
              word_cnt   <= '0;
`endif
              state      <= hdr_rw ? WRITE : RD_LOAD;
            end
          end
        end

        SKIP: begin
          hdr_cnt <= hdr_cnt + 1'b1;
          if (hdr_cnt == HDR_LAST) begin
            state <= IDLE;
          end
        end

        WRITE: begin
          if (bus.valid) begin
            wr_shift <= wr_word[DATA_WIDTH-2:0];
`ifdef SERIAL_SLAVE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (!is_burst || bus.last) begin
                state <= FINISH;
              end else begin
                addr <= addr_inc;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef SERIAL_SLAVE_TIMEOUT_EN
          else if (idle_cnt == TO_LAST) begin
            // Partial word is dropped; nothing reaches memory
            bus.err <= 1'b1;
            state   <= FINISH;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        RD_LOAD: begin
          rd_started <= 1'b0;
          state      <= READ;
        end

        READ: begin
          if (rd_start) begin
            // mem_q already holds this word; moving addr on prefetches the next one
            bus.rD       <= mem_q[DATA_WIDTH-1];
            bus.rD_valid <= 1'b1;
            out_shift    <= {mem_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt      <= BCW'(1);
            rd_started   <= 1'b1;
            stop_req     <= 1'b0;
            addr         <= addr_inc;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
            word_cnt     <= word_cnt + 1'b1;
`endif
          end else if (word_done) begin
            bus.rD       <= 1'b0;
            bus.rD_valid <= 1'b0;
            bus.err      <= rd_over;
            state        <= FINISH;
          end else begin
            bus.rD    <= out_shift[DATA_WIDTH-1];
            out_shift <= {out_shift[DATA_WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            if (is_burst && bus.last) begin
              stop_req <= 1'b1;
            end
          end
        end

        FINISH: begin
          bus.ready <= 1'b1;
          ones_cnt  <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_slave_port.sv
// Directed bench for serial_bus_slave_port: single/burst write and read,
// foreign and reserved IDs, valid pauses, reset mid-transfer, and the
// optional timeout when SERIAL_SLAVE_TIMEOUT_EN is defined.
module tb_serial_bus_slave_port;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_bus_slave_port_if bus_if ();

  serial_bus_slave_port dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Inputs change on negedges; outputs are observed on negedges too
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.control = 1'b0;
      bus_if.valid   = 1'b0;
      bus_if.wD      = 1'b0;
      bus_if.last    = 1'b0;
    end
  endtask

  task automatic send_header(input logic [1:0] id, input logic rw, input logic burst,
                             input logic [11:0] addr);
    logic [15:0] h;
    h = {id, rw, burst, addr};
    repeat (3) begin
      @(negedge clk);
      bus_if.control = 1'b1;
    end
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      bus_if.control = h[i];
    end
  endtask

  // words: word k in bits [31-8k -: 8]; pause_len cycles of valid=0 before bit pause_at of word 0
  task automatic do_write(input string name, input logic [11:0] addr, input logic burst,
                          input logic [31:0] words, input int n, input int pause_at,
                          input int pause_len);
    send_header(2'd1, 1'b1, burst, addr);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        bus_if.control = 1'b0;
        if (k == 0 && i == 0) begin
          n_cmp++;
          if (bus_if.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_low: got %b want 0", name, bus_if.ready);
          end
        end
        if (k == 0 && i == pause_at) begin
          bus_if.valid = 1'b0;
          bus_if.wD    = ~words[31-8*k-i];
          repeat (pause_len) @(negedge clk);
          n_cmp++;
          if ({bus_if.ready, bus_if.err} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s pause_state: got ready/err %b want 00", name, {bus_if.ready, bus_if.err});
          end
        end
        bus_if.valid = 1'b1;
        bus_if.wD    = words[31-8*k-i];
        bus_if.last  = burst && (k == n - 1) && (i == 7);
      end
    end
    @(negedge clk);
    bus_if.valid = 1'b0;
    bus_if.wD    = 1'b0;
    bus_if.last  = 1'b0;
    n_cmp++;
    if (bus_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s finish_ready: got %b want 0", name, bus_if.ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_back: got %b want 1", name, bus_if.ready);
    end
    $display("write %s addr=%h words=%0d data=%h", name, addr, n, words);
    idle_cycles(2);
  endtask

  // last is driven high during every cycle of the final expected word
  task automatic do_read(input string name, input logic [11:0] addr, input logic burst,
                         input logic [31:0] words, input int n);
    logic [31:0] got;
    got = '0;
    send_header(2'd1, 1'b0, burst, addr);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus_if.control = 1'b0;
      n_cmp++;
      if ({bus_if.ready, bus_if.rD_valid, bus_if.rD} !== 3'b000) begin
        n_bad++;
        $display("FAIL %s latency_c%0d: got ready/rD_valid/rD %b want 000", name, c,
                 {bus_if.ready, bus_if.rD_valid, bus_if.rD});
      end
    end
    for (int j = 0; j < 8 * n; j++) begin
      @(negedge clk);
      got[31-j] = bus_if.rD;
      n_cmp++;
      if ({bus_if.rD_valid, bus_if.rD, bus_if.err} !== {1'b1, words[31-j], 1'b0}) begin
        n_bad++;
        $display("FAIL %s bit%0d: got rD_valid/rD/err %b want %b", name, j,
                 {bus_if.rD_valid, bus_if.rD, bus_if.err}, {1'b1, words[31-j], 1'b0});
      end
      bus_if.last = (j >= 8 * (n - 1));
    end
    @(negedge clk);
    bus_if.last = 1'b0;
    n_cmp++;
    if ({bus_if.rD_valid, bus_if.rD} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s end_of_data: got rD_valid/rD %b want 00", name, {bus_if.rD_valid, bus_if.rD});
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_back: got %b want 1", name, bus_if.ready);
    end
    $display("read  %s addr=%h words=%0d got=%h want=%h", name, addr, n, got, words);
    idle_cycles(2);
  endtask

  task automatic test_reset();
    bus_if.control = 1'b0;
    bus_if.wD      = 1'b0;
    bus_if.valid   = 1'b0;
    bus_if.last    = 1'b0;
    rstN           = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_if.ready, bus_if.rD_valid, bus_if.rD, bus_if.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_state: got ready/rD_valid/rD/err %b want 1000",
               {bus_if.ready, bus_if.rD_valid, bus_if.rD, bus_if.err});
    end
    rstN = 1'b1;
    $display("reset released");
    idle_cycles(2);
  endtask

  task automatic test_single();
    do_write("single_wr", 12'h010, 1'b0, {8'hA5, 24'h0}, 1, -1, 0);
    do_read("single_rd", 12'h010, 1'b0, {8'hA5, 24'h0}, 1);
  endtask

  task automatic test_burst_wrap();
    do_write("burst_wr", 12'hFFE, 1'b1, 32'h11223344, 4, -1, 0);
    do_read("burst_rd", 12'hFFE, 1'b1, 32'h11223344, 4);
    do_read("wrap_rd", 12'h000, 1'b0, {8'h33, 24'h0}, 1);
  endtask

  task automatic test_foreign_ids();
    // ID 2 write of 0xFF to 0x010, then a reserved-ID-0 read of the same address
    send_header(2'd2, 1'b1, 1'b0, 12'h010);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus_if.control = 1'b0;
      bus_if.valid   = 1'b1;
      bus_if.wD      = 1'b1;
      n_cmp++;
      if ({bus_if.ready, bus_if.rD_valid} !== 2'b10) begin
        n_bad++;
        $display("FAIL id2_quiet c%0d: got ready/rD_valid %b want 10", c, {bus_if.ready, bus_if.rD_valid});
      end
    end
    idle_cycles(2);
    send_header(2'd0, 1'b0, 1'b0, 12'h010);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus_if.control = 1'b0;
      n_cmp++;
      if ({bus_if.ready, bus_if.rD_valid, bus_if.rD} !== 3'b100) begin
        n_bad++;
        $display("FAIL id0_quiet c%0d: got ready/rD_valid/rD %b want 100", c,
                 {bus_if.ready, bus_if.rD_valid, bus_if.rD});
      end
    end
    $display("foreign headers ID=2 and ID=0 sent");
    idle_cycles(2);
    do_read("after_foreign", 12'h010, 1'b0, {8'hA5, 24'h0}, 1);
  endtask

  task automatic test_valid_pause();
    do_write("pause_wr", 12'h020, 1'b0, {8'h5A, 24'h0}, 1, 4, 5);
    do_read("pause_rd", 12'h020, 1'b0, {8'h5A, 24'h0}, 1);
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] w;
    do_write("pre_102", 12'h102, 1'b0, {8'h77, 24'h0}, 1, -1, 0);
    send_header(2'd1, 1'b1, 1'b1, 12'h100);
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 8'hC3 : ((k == 1) ? 8'h3C : 8'h99);
      for (int i = 0; i < 8; i++) begin
        if (k == 2 && i == 3) break;
        @(negedge clk);
        bus_if.control = 1'b0;
        bus_if.valid   = 1'b1;
        bus_if.wD      = w[7-i];
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid busy_before: got ready %b want 0", bus_if.ready);
    end
    #2 rstN = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.ready, bus_if.rD_valid, bus_if.rD, bus_if.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_mid immediate: got ready/rD_valid/rD/err %b want 1000",
               {bus_if.ready, bus_if.rD_valid, bus_if.rD, bus_if.err});
    end
    idle_cycles(2);
    rstN = 1'b1;
    $display("reset asserted mid burst write at 0x100");
    idle_cycles(2);
    do_read("after_rst", 12'h100, 1'b1, {8'hC3, 8'h3C, 8'h77, 8'h00}, 3);
  endtask

  task automatic test_timeout();
    int err_cycles;
    int err_at;
    do_write("pre_030", 12'h030, 1'b0, {8'h3C, 24'h0}, 1, -1, 0);
`ifdef SERIAL_SLAVE_TIMEOUT_EN
    err_cycles = 0;
    err_at     = -1;
    send_header(2'd1, 1'b1, 1'b0, 12'h030);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus_if.control = 1'b0;
      bus_if.valid   = 1'b0;
      if (bus_if.err === 1'b1) begin
        err_cycles++;
        if (err_at < 0) err_at = c;
      end
    end
    n_cmp++;
    if (err_cycles !== 1 || err_at !== 257) begin
      n_bad++;
      $display("FAIL timeout_err: got %0d pulses at cycle %0d want 1 at 257", err_cycles, err_at);
    end
    n_cmp++;
    if (bus_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_ready: got %b want 1", bus_if.ready);
    end
    $display("timeout write at 0x030 err_pulses=%0d", err_cycles);
    idle_cycles(2);
    do_read("timeout_rd", 12'h030, 1'b0, {8'h3C, 24'h0}, 1);
`else
    err_cycles = 0;
    err_at     = 0;
    // Without the timeout a long pause is just a pause
    do_write("long_pause", 12'h030, 1'b0, {8'hE7, 24'h0}, 1, 2, 300);
    do_read("long_pause_rd", 12'h030, 1'b0, {8'hE7, 24'h0}, 1);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_foreign_ids();
    test_valid_pause();
    test_reset_mid_burst();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_bus_slave_port.md
Name: serial_bus_slave_port

Overview:
- Parametrised serial-bus slave endpoint with an internal word memory.
- Decodes the serial control header `111 | slave ID | R/W | burst | start address` on `control`.
- Writes: shifts in words on `wD`. Reads: shifts out words on `rD`.
- Single and burst transfers, with address auto-increment and wrap-around. Sits behind the bus interconnect, one instance per slave ID.

Parameters:
- DATA_WIDTH, 8, bits per data word (serial MSB first).
- MEM_DEPTH, 4096, number of words in the internal memory.
- ADDR_WIDTH, $clog2(MEM_DEPTH), width of the start-address field.
- SLAVES, 3, number of slaves on the bus.
- SLAVE_ID_WIDTH, $clog2(SLAVES+1), width of the ID field.
- SLAVEID, 1, this port's ID (0 reserved, never matches).
- TIMEOUT_CYCLES, 256, idle-valid limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rstN  in  1  reset; one clock; asynchronous, active-low.
- control  in  1  serial header line, one bit per clk.
- wD  in  1  serial write data, qualified by valid.
- valid  in  1  master write-bit qualifier.
- last  in  1  master end-of-burst flag.
- rD  out  1  serial read data.
- rD_valid  out  1  rD qualifier.
- ready  out  1  high when idle and able to accept a header.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset: asynchronous. `ready=1`, `rD=0`, `rD_valid=0`, `err=0`, FSM goes to IDLE, counters cleared. Memory contents are not cleared.
- States: IDLE, HEADER, SKIP, WRITE, RD_LOAD, READ, FINISH.
- IDLE:
  - Counts consecutive `control=1` samples; a 0 restarts the count.
  - Third consecutive 1 → HEADER.
- HEADER:
  - Samples `SLAVE_ID_WIDTH + 2 + ADDR_WIDTH` bits, MSB first: ID, R/W (1=write, 0=read), burst, address.
  - ID mismatch, or address >= MEM_DEPTH → SKIP.
  - SKIP discards the remaining header bits, then returns to IDLE. `ready` stays 1 and there is no other output activity.
- Header accepted: `ready=0` from the cycle after the final address bit until FINISH completes.
- WRITE:
  - A bit is shifted in only on cycles with `valid=1`; `valid=0` pauses the shift with no data loss.
  - On the DATA_WIDTH-th bit, the word is written to mem[addr].
  - Non-burst: after one word → FINISH.
  - Burst: addr increments after each word; MEM_DEPTH-1 wraps to 0. Continues until `last=1` is sampled together with the final bit of a word; that word is written, then → FINISH.
- RD_LOAD: one-cycle memory fetch.
- READ:
  - First bit on `rD` with `rD_valid=1` two cycles after the edge that samples the final address bit.
  - Subsequent words follow back-to-back with no gap (prefetch the next word).
  - Non-burst: exactly DATA_WIDTH valid bits.
  - Burst: `last=1` sampled at any cycle of a word → that word completes, then stop.
  - addr wraps as in WRITE. `rD=0` whenever `rD_valid=0`.
- FINISH: one cycle, then `ready=1` and → IDLE.
- Headers arriving while `ready=0` are ignored, and `control` is not monitored. Start detection begins fresh in IDLE.
- `last` is ignored in non-burst mode.
- `wD`/`valid` are ignored outside WRITE.

Optional Feature:
- Macro: SERIAL_SLAVE_TIMEOUT_EN.
- With the macro: in WRITE, a counter counts consecutive cycles with `valid=0`.
  - Reaching TIMEOUT_CYCLES → partial word discarded, `err` pulses 1 cycle, → FINISH.
  - In READ, a burst with no `last` after MEM_DEPTH words → `err` pulse, → FINISH.
- Without the macro: no timeout, no burst-length check, `err` tied to 0.

Test Plan:
- Header ID=1, write, non-burst, addr 0x010; data 0xA5 with valid → mem[0x010]=0xA5, `ready` low then high.
- Then read, non-burst, addr 0x010 → `rD` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, first bit 2 cycles after the last address bit, `rD_valid=1` for exactly 8 cycles.
- Burst write at 0xFFE: 0x11, 0x22, 0x33, 0x44, `last` on the final bit of 0x44 → mem[0xFFE]=0x11, mem[0xFFF]=0x22, mem[0x000]=0x33, mem[0x001]=0x44.
  - Burst read from 0xFFE, `last` during the 4th word → same 4 bytes back-to-back (32 `rD_valid` cycles).
- Header with ID=2, then ID=0 → `ready` stays 1, `rD_valid` stays 0, memory unchanged.
- Write 0x5A with `valid` low for 5 cycles after bit 3 → mem[addr]=0x5A.
- `rstN` low mid burst write after 2 full words → outputs immediately at reset values.
  - First 2 words retained in memory.
  - A following header is accepted normally.
- With SERIAL_SLAVE_TIMEOUT_EN: write header, then `valid` held 0 for 256 cycles → `err` pulses for exactly 1 cycle, `ready=1`, memory unchanged.
